// File: rtl/seg_pkg.sv
// Shared constants and width helper for the seven-segment scan driver.
package seg_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam logic [7:0] AN_OFF     = 8'hFF;

  // Counter width for values 0..value-1, never narrower than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/seg_tick_div.sv
// Slot timer: counts 0..DIV-1 and flags the last cycle of each digit slot.
module seg_tick_div #(
  parameter int DIV = 100000,
  parameter int W   = seg_pkg::clog2(DIV)
) (
  input  logic         iClk,
  input  logic         iRst_n,
  output logic [W-1:0] oTick,
  output logic         oSlotEnd
);

  logic [W-1:0] tick_q, tick_d;

  always_comb begin
    oSlotEnd = (tick_q == W'(DIV - 1));
    tick_d   = oSlotEnd ? '0 : tick_q + 1'b1;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) tick_q <= '0;
    else         tick_q <= tick_d;
  end

  assign oTick = tick_q;

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed scan driver for a common-anode 7-segment display with
// leading-zero blanking, anti-ghost slot blanking and frame-aligned updates.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000
) (
  input  logic                    iClk,
  input  logic                    iRst_n,
  input  logic                    iLoad,
  input  logic [4*NUM_DIGITS-1:0] iBcd,
  input  logic [NUM_DIGITS-1:0]   iDpMask,
  input  logic                    iBlankLz,
  input  logic                    iEnable,
  output logic [3:0]              oDigit,
  output logic [NUM_DIGITS-1:0]   oAn,
  output logic                    oDp,
  output logic                    oFrame
);

  localparam int TICK_W = clog2(REFRESH_DIV);
  localparam int IDX_W  = clog2(NUM_DIGITS);
  localparam int BW     = 4 * NUM_DIGITS;

  logic [TICK_W-1:0]     tick;
  logic                  slot_end;
  logic                  frame_wrap;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  frame_q, frame_d;
  logic [BW-1:0]         disp_q, disp_d, pend_q, pend_d;
  logic [NUM_DIGITS-1:0] dp_reg_q, dp_reg_d, pend_dp_q, pend_dp_d;
  logic                  pending_q, pending_d;
  logic [3:0]            digit_q, digit_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  odp_q, odp_d;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_above;
  logic                  lit;
  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_lz;

  seg_tick_div #(.DIV(REFRESH_DIV), .W(TICK_W)) u_tick (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .oTick    (tick),
    .oSlotEnd (slot_end)
  );

  // A load landing in the wrap cycle bypasses the pending stage entirely.
  always_comb begin
    frame_wrap = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
    idx_d      = idx_q;
    if (slot_end) idx_d = frame_wrap ? '0 : idx_q + 1'b1;
    frame_d    = frame_wrap;
    disp_d     = disp_q;
    dp_reg_d   = dp_reg_q;
    pend_d     = pend_q;
    pend_dp_d  = pend_dp_q;
    pending_d  = pending_q;
    if (frame_wrap) begin
      if (iLoad) begin
        disp_d    = iBcd;
        dp_reg_d  = iDpMask;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = pend_q;
        dp_reg_d  = pend_dp_q;
        pending_d = 1'b0;
      end
    end else if (iLoad) begin
      pend_d    = iBcd;
      pend_dp_d = iDpMask;
      pending_d = 1'b1;
    end
  end

  // Digit k is a leading zero when it and every more significant digit are zero.
  always_comb begin
    zero_above = 1'b1;
    lz_mask    = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (disp_q[4*k +: 4] == 4'h0);
      lz_mask[k] = iBlankLz && zero_above && !dp_reg_q[k];
    end
  end

  always_comb begin
    lit     = iEnable && (tick >= TICK_W'(BLANK_CYC));
    cur_nib = BLANK_CODE;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib = disp_q[4*k +: 4];
        cur_dp  = dp_reg_q[k];
        cur_lz  = lz_mask[k];
      end
    end
    an_d    = AN_OFF[NUM_DIGITS-1:0];
    digit_d = BLANK_CODE;
    odp_d   = 1'b1;
    if (lit) begin
      for (int k = 0; k < NUM_DIGITS; k++) an_d[k] = (idx_q != IDX_W'(k));
      digit_d = cur_lz ? BLANK_CODE : cur_nib;
      odp_d   = ~cur_dp;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      idx_q     <= '0;
      frame_q   <= 1'b0;
      disp_q    <= '0;
      dp_reg_q  <= '0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      pending_q <= 1'b0;
      digit_q   <= BLANK_CODE;
      an_q      <= AN_OFF[NUM_DIGITS-1:0];
      odp_q     <= 1'b1;
    end else begin
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      disp_q    <= disp_d;
      dp_reg_q  <= dp_reg_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      pending_q <= pending_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
      odp_q     <= odp_d;
    end
  end

  assign oDigit = digit_q;
  assign oAn    = an_q;
  assign oDp    = odp_q;
  assign oFrame = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: cycle-count reference model plus directed frame checks.
module tb_seg_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd = '0;
  logic [3:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  o_digit;
  logic [3:0]  o_an;
  logic        o_dp;
  logic        o_frame;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .iClk     (clk),
    .iRst_n   (rst_n),
    .iLoad    (load),
    .iBcd     (bcd),
    .iDpMask  (dp_mask),
    .iBlankLz (blank_lz),
    .iEnable  (enable),
    .oDigit   (o_digit),
    .oAn      (o_an),
    .oDp      (o_dp),
    .oFrame   (o_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot position follows directly from cycles since reset.
  int          m_cyc, m_t, m_i;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pend_dp, m_pat;
  bit          m_pending, m_blanked, m_lz, m_wrap;
  logic [3:0]  exp_digit, exp_an;
  logic        exp_dp, exp_frame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_disp = '0; m_dp = '0; m_pend = '0; m_pend_dp = '0; m_pending = 0;
      exp_digit = 4'hF; exp_an = 4'hF; exp_dp = 1'b1; exp_frame = 1'b0;
    end else begin
      m_t = m_cyc % DIV;
      m_i = (m_cyc / DIV) % N;
      m_blanked = (m_t < BLANK) || !enable;
      m_lz = blank_lz && (m_i != 0) && ((m_disp >> (4 * m_i)) == 16'h0) && !m_dp[m_i];
      m_pat = 4'b0001 << m_i;
      exp_an = m_blanked ? 4'hF : ~m_pat;
      exp_digit = (m_blanked || m_lz) ? 4'hF : m_disp[4*m_i +: 4];
      exp_dp = m_blanked ? 1'b1 : ~m_dp[m_i];
      m_wrap = (m_t == DIV - 1) && (m_i == N - 1);
      exp_frame = m_wrap;
      if (m_wrap) begin
        if (load) begin m_disp = bcd; m_dp = dp_mask; m_pending = 0; end
        else if (m_pending) begin m_disp = m_pend; m_dp = m_pend_dp; m_pending = 0; end
      end else if (load) begin
        m_pend = bcd; m_pend_dp = dp_mask; m_pending = 1;
      end
      m_cyc++;
    end
  end

  // Compare and observe on the falling edge, away from output updates.
  logic [3:0] seen_dig[N];
  logic       seen_dp[N];
  int         lit_cnt[N];
  int         frame_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("oDigit", {28'h0, o_digit}, {28'h0, exp_digit});
      chk("oAn", {28'h0, o_an}, {28'h0, exp_an});
      chk("oDp", {31'h0, o_dp}, {31'h0, exp_dp});
      chk("oFrame", {31'h0, o_frame}, {31'h0, exp_frame});
    end
    if (o_frame === 1'b1) frame_cnt++;
    for (int i = 0; i < N; i++) begin
      logic [3:0] pat;
      pat = 4'b0001 << i;
      if (o_an === ~pat) begin
        seen_dig[i] = o_digit;
        seen_dp[i]  = o_dp;
        lit_cnt[i]++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_seen();
    for (int i = 0; i < N; i++) begin
      seen_dig[i] = 4'hx;
      seen_dp[i]  = 1'bx;
      lit_cnt[i]  = 0;
    end
  endtask

  task automatic wait_frame();
    int f0;
    bit got;
    f0 = frame_cnt;
    got = 0;
    for (int c = 0; c < 3 * FRAME && !got; c++) begin
      step();
      if (frame_cnt != f0) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL frame_timeout: got no oFrame pulse within %0d cycles, required one", 3 * FRAME);
    end
  endtask

  task automatic capture();
    clear_seen();
    repeat (FRAME) step();
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dpm);
    bcd = v; dp_mask = dpm; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic chk_digits(input string name, input logic [15:0] exp);
    for (int i = 0; i < N; i++) chk(name, {28'h0, seen_dig[i]}, {28'h0, exp[4*i +: 4]});
  endtask

  initial begin
    int f0;
    int tot;
    clear_seen();
    repeat (3) step();
    chk_en = 1'b1;
    chk("rst_an", {28'h0, o_an}, 32'hF);
    chk("rst_digit", {28'h0, o_digit}, 32'hF);
    chk("rst_dp", {31'h0, o_dp}, 32'h1);
    chk("rst_frame", {31'h0, o_frame}, 32'h0);
    rst_n = 1'b1;

    // First frame after release: each digit lit for DIV-BLANK cycles, one wrap pulse.
    f0 = frame_cnt;
    capture();
    for (int i = 0; i < N; i++) chk("lit_cycles", lit_cnt[i], 6);
    chk("first_frame_pulses", frame_cnt - f0, 1);

    // Mid-frame load holds the old value until the wrap.
    repeat (5) step();
    pulse_load(16'h1234, 4'b0000);
    clear_seen();
    wait_frame();
    for (int i = 1; i < N; i++) chk("hold_old", {28'h0, seen_dig[i]}, 32'h0);
    capture();
    chk_digits("show_1234", 16'h1234);

    // Leading-zero blanking and decimal-point override.
    blank_lz = 1'b1;
    step();
    pulse_load(16'h0050, 4'b0000);
    wait_frame();
    capture();
    chk_digits("lz_on", 16'hFF50);
    blank_lz = 1'b0;
    capture();
    chk_digits("lz_off", 16'h0050);
    blank_lz = 1'b1;
    step();
    pulse_load(16'h0050, 4'b1000);
    wait_frame();
    capture();
    chk("dp_digit3", {28'h0, seen_dig[3]}, 32'h0);
    chk("dp_lit3", {31'h0, seen_dp[3]}, 32'h0);
    chk("dp_digit2_blank", {28'h0, seen_dig[2]}, 32'hF);
    blank_lz = 1'b0;

    // Last load in a frame wins.
    repeat (3) step();
    pulse_load(16'h1111, 4'b0000);
    repeat (6) step();
    pulse_load(16'h2222, 4'b0000);
    wait_frame();
    capture();
    chk_digits("last_load_wins", 16'h2222);

    // Load coinciding with the wrap is shown in the very next frame.
    repeat (FRAME - 1) step();
    pulse_load(16'h5678, 4'b0000);
    chk("wrap_pulse", {31'h0, o_frame}, 32'h1);
    capture();
    chk_digits("wrap_load", 16'h5678);

    // Disabled display keeps scanning.
    enable = 1'b0;
    f0 = frame_cnt;
    capture();
    tot = 0;
    for (int i = 0; i < N; i++) tot += lit_cnt[i];
    chk("disabled_lit", tot, 0);
    chk("disabled_pulses", frame_cnt - f0, 1);
    enable = 1'b1;
    capture();
    chk_digits("reenabled", 16'h5678);

    // Randomised traffic against the model.
    for (int c = 0; c < 800; c++) begin
      load     = ($urandom_range(0, 7) == 0);
      bcd      = 16'($urandom);
      dp_mask  = 4'($urandom);
      blank_lz = 1'($urandom);
      enable   = ($urandom_range(0, 9) != 0);
      step();
    end
    load = 1'b0; enable = 1'b1; blank_lz = 1'b0;

    // Reset in slot 2 with a pending load discards it.
    wait_frame();
    repeat (2 * DIV + 2) step();
    pulse_load(16'h9999, 4'b1111);
    repeat (2) step();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_an", {28'h0, o_an}, 32'hF);
    chk("midrst_digit", {28'h0, o_digit}, 32'hF);
    chk("midrst_dp", {31'h0, o_dp}, 32'h1);
    chk("midrst_frame", {31'h0, o_frame}, 32'h0);
    repeat (3) step();
    rst_n = 1'b1;
    capture();
    chk_digits("post_rst_f0", 16'h0000);
    capture();
    chk_digits("post_rst_f1", 16'h0000);
    for (int i = 0; i < N; i++) chk("post_rst_dp", {31'h0, seen_dp[i]}, 32'h1);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
